shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter and load sequencer for a shared WIDTH-bit storage register built from D flip-flops.
//  Up to NREQ requesters compete for it; the winner's data is captured into the register, and the winner holds ownership until it releases.
//  A hold timeout prevents one requester from starving the others.

---
 rtl/shared_reg_arbiter_pkg.sv | 15 +
 rtl/rr_pick.sv | 26 ++
 rtl/shared_reg_arbiter.sv | 101 ++++++++++
 tb/tb_shared_reg_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and counter sizing.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StHold = 2'd2
  } state_e;

  // Hold counter only needs to reach timeout-1.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int unsigned pos;
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (!any && eligible[IDW'(pos)]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and load sequencer for a shared register with hold timeout.
// All state changes on the falling clock edge; reset is synchronous and active-low.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        owner,
  output logic [WIDTH-1:0]      q,
  output logic                  ack,
  output logic                  err
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  state_e          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] mask;
  logic [CntW-1:0] cnt;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .eligible (req & ~mask),
    .ptr      (ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Explicit wrap so non-power-of-two NREQ never produces an out-of-range pointer.
  assign ptr_next = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(negedge clk) begin
    if (!reset) begin
      state <= StIdle;
      gnt   <= '0;
      owner <= '0;
      q     <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      ptr   <= '0;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      ack  <= 1'b0;
      err  <= 1'b0;
      mask <= mask & req;
      unique case (state)
        StIdle: begin
          if (pick_any) begin
            owner <= pick_idx;
            gnt   <= NREQ'(1) << pick_idx;
            state <= StLoad;
          end
        end
        StLoad: begin
          if (req[owner]) begin
            q     <= wdata[owner*WIDTH +: WIDTH];
            ack   <= 1'b1;
            cnt   <= '0;
            state <= StHold;
          end else begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= StIdle;
          end
        end
        StHold: begin
          if (!req[owner]) begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= StIdle;
          end else if (cnt == CntW'(TIMEOUT - 1)) begin
            gnt   <= '0;
            err   <= 1'b1;
            mask  <= (mask & req) | (NREQ'(1) << owner);
            ptr   <= ptr_next;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed scenarios followed by randomized requesters.
module tb_shared_reg_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b1;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        owner;
  logic [WIDTH-1:0]      q;
  logic                  ack;
  logic                  err;

  int n_checks = 0;
  int n_errors = 0;

  shared_reg_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .q     (q),
    .ack   (ack),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of who holds the register.
  typedef struct {
    int         kind;   // 0 grant, 1 ack, 2 err
    int         idx;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         m_phase, m_owner, m_ptr, m_held;
  logic [3:0] m_mask, m_gnt;
  logic [7:0] m_q;

  task automatic model_step();
    logic [3:0] old_mask;
    bit         found;
    int         i;
    old_mask = m_mask;
    found    = 0;
    if (!reset) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      m_mask  = '0; m_q = '0; m_gnt = '0;
      return;
    end
    m_mask = m_mask & req;
    case (m_phase)
      0: begin
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (!found && req[i] && !old_mask[i]) begin
            found   = 1;
            m_owner = i;
            m_phase = 1;
            exp_q.push_back('{kind: 0, idx: i, data: 8'h00});
          end
        end
      end
      1: begin
        if (req[m_owner]) begin
          m_q     = wdata[m_owner*WIDTH +: WIDTH];
          m_held  = 0;
          m_phase = 2;
          exp_q.push_back('{kind: 1, idx: m_owner, data: m_q});
        end else begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_phase = 0;
        end
      end
      default: begin
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_phase = 0;
        end else begin
          m_held++;
          if (m_held == TIMEOUT) begin
            m_mask[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % NREQ;
            m_phase = 0;
            exp_q.push_back('{kind: 2, idx: m_owner, data: 8'h00});
          end
        end
      end
    endcase
    m_gnt = (m_phase != 0) ? (4'b0001 << m_owner) : 4'b0000;
  endtask

  initial begin
    m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    m_mask = '0; m_q = '0; m_gnt = '0;
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic take(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: got event kind %0d owner %0d, expected none at %0t",
               kind, owner, $time);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_kind", kind, e.kind);
    chk("sb_owner", 32'(owner), e.idx);
    if (kind == 1) chk("sb_q", 32'(q), 32'(e.data));
  endtask

  // Monitor: samples on the rising edge, half a cycle after the falling-edge update.
  initial begin
    logic [3:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(posedge clk);
      if (gnt != 0 && prev_gnt == 0) take(0);
      if (ack === 1'b1) take(1);
      if (err === 1'b1) take(2);
      chk("sb_missed", exp_q.size(), 0);
      exp_q.delete();
      chk("cyc_gnt", 32'(gnt), 32'(m_gnt));
      chk("cyc_q", 32'(q), 32'(m_q));
      chk("ack_err_excl", 32'(ack & err), 0);
      prev_gnt = gnt;
    end
  end

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    while (gnt == 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (gnt == 0) begin
      n_errors++;
      $display("FAIL %s: got no grant within 10 cycles, expected a grant", name);
    end
  endtask

  initial begin
    int         exp_own;
    int         n;
    logic [7:0] q_before;

    // 1: reset with all requests high
    reset = 1'b0;
    req   = 4'hF;
    wdata = 32'h44332211;
    repeat (2) @(posedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_owner", 32'(owner), 0);
    reset = 1'b1;
    req   = 4'h0;
    @(posedge clk);

    // 2: single requester
    req = 4'b0100;
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    @(posedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_ack", 32'(ack), 1);
    req = 4'b0000;
    @(posedge clk);
    chk("single_rel", 32'(gnt), 0);

    // 4: pointer now 3, requester 0 must win over 1
    req = 4'b0011;
    @(posedge clk);
    chk("wrap_owner", 32'(owner), 0);
    chk("wrap_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    req = 4'b0000;
    repeat (2) @(posedge clk);

    // 3: rotation with everyone requesting; pointer left at 1
    wdata   = 32'hD4C3B2A1;
    req     = 4'hF;
    exp_own = 1;
    for (int r = 0; r < 5; r++) begin
      wait_gnt("rot_wait");
      chk("rot_owner", 32'(owner), exp_own);
      @(posedge clk);
      chk("rot_ack", 32'(ack), 1);
      chk("rot_q", 32'(q), 32'(wdata[exp_own*WIDTH +: WIDTH]));
      req[exp_own] = 1'b0;
      @(posedge clk);
      chk("rot_rel", 32'(gnt), 0);
      req[exp_own] = 1'b1;
      exp_own = (exp_own + 1) % NREQ;
    end
    req = 4'h0;
    repeat (3) @(posedge clk);

    // 5: timeout on requester 1 while 3 waits
    req = 4'b0010;
    wait_gnt("to_wait");
    chk("to_owner", 32'(owner), 1);
    @(posedge clk);
    chk("to_ack", 32'(ack), 1);
    req[3] = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("to_latency", n, TIMEOUT);
    chk("to_gnt_off", 32'(gnt), 0);
    @(posedge clk);
    chk("to_next_gnt", 32'(gnt), 32'h8);
    @(posedge clk);
    req[3] = 1'b0;
    repeat (5) @(posedge clk);
    chk("to_masked", 32'(gnt), 0);
    req[1] = 1'b0;
    @(posedge clk);
    req[1] = 1'b1;
    wait_gnt("to_regrant");
    chk("to_regrant_owner", 32'(owner), 1);
    req = 4'h0;
    repeat (3) @(posedge clk);

    // 6: abort in LOAD, then reset during HOLD
    req = 4'b0001;
    wait_gnt("abort_wait");
    q_before = q;
    req = 4'b0000;
    @(posedge clk);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_q", 32'(q), 32'(q_before));
    req = 4'b0001;
    wait_gnt("mid_wait");
    repeat (4) @(posedge clk);
    reset = 1'b0;
    @(posedge clk);
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_q", 32'(q), 0);
    chk("mid_owner", 32'(owner), 0);
    chk("mid_ack_err", 32'({ack, err}), 0);
    reset = 1'b1;
    req   = 4'h0;
    repeat (2) @(posedge clk);

    // Randomized requesters checked by the scoreboard
    for (int c = 0; c < 2000; c++) begin
      wdata = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else         req[i] = ($urandom_range(0, 23) != 0);
      end
      @(posedge clk);
    end
    req = 4'h0;
    repeat (5) @(posedge clk);
    chk("final_idle", 32'(gnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
